// File: rtl/street_tiles_pkg.sv
// Shared constants and types for the street-tile drawing path.
// The optional per-frame overlap counter is enabled by defining STREET_TILE_HITCOUNT_EN.
package street_tiles_pkg;

    localparam int NUM_TILES_DEF = 10;
    localparam int COLOR_W_DEF   = 8;
    localparam int SCREEN_W_DEF  = 640;
    localparam int SCREEN_H_DEF  = 480;

    typedef logic [3:0] tile_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        HIT  = 1'b1
    } collision_state_t;

endpackage

// File: rtl/street_tile_mux_tile_priority_encoder.sv
// Combinational lowest-index-first encoder over the masked tile requests.
module tile_priority_encoder
    import street_tiles_pkg::*;
#(
    parameter int N = NUM_TILES_DEF
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output tile_idx_t    idx_o
);

    // Scanning from the top down lets the lowest active index overwrite last.
    always_comb begin
        valid_o = |req_i;
        idx_o   = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_o = req_i[i] ? tile_idx_t'(i) : idx_o;
        end
    end

endmodule

// File: rtl/street_tile_mux.sv
// Two-stage priority mux of street-tile pixels plus per-frame tile/player collision detect.
// Define STREET_TILE_HITCOUNT_EN to build the saturating overlapPixelCount counter.
module street_tile_mux
    import street_tiles_pkg::*;
#(
    parameter int NUM_TILES = NUM_TILES_DEF,
    parameter int COLOR_W   = COLOR_W_DEF,
    parameter int SCREEN_W  = SCREEN_W_DEF,
    parameter int SCREEN_H  = SCREEN_H_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           startOfFrame,
    input  logic [10:0]                    pixelX,
    input  logic [10:0]                    pixelY,
    input  logic [NUM_TILES-1:0]           drawingRequestVector,
    input  logic [NUM_TILES*COLOR_W-1:0]   RGBoutVector,
    input  logic                           playerDrawingRequest,
    output logic                           tileDrawingRequest,
    output logic [COLOR_W-1:0]             tileRGB,
    output logic [3:0]                     tileIndex,
    output logic                           tileCollision,
    output logic [3:0]                     collisionTileIndex,
    output logic [15:0]                    overlapPixelCount
);

    localparam logic [10:0] SCREEN_W_L = 11'(SCREEN_W);
    localparam logic [10:0] SCREEN_H_L = 11'(SCREEN_H);

    logic [NUM_TILES-1:0]         req_q;
    logic [NUM_TILES*COLOR_W-1:0] rgb_q;
    logic                         player_q;
    logic                         vis_q;

    logic [NUM_TILES-1:0]         masked_req;
    logic                         enc_valid;
    tile_idx_t                    enc_idx;
    logic [COLOR_W-1:0]           sel_rgb;
    logic                         overlap;

    logic                         tile_req_q;
    logic [COLOR_W-1:0]           tile_rgb_q;
    tile_idx_t                    tile_idx_q;

    collision_state_t             state_q, state_d, state_base;
    logic                         first_hit;
    logic                         collision_q;
    tile_idx_t                    coll_idx_q, coll_idx_d;

    // Stage 1: capture raw inputs and the on-screen flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q    <= '0;
            rgb_q    <= '0;
            player_q <= 1'b0;
            vis_q    <= 1'b0;
        end else begin
            req_q    <= drawingRequestVector;
            rgb_q    <= RGBoutVector;
            player_q <= playerDrawingRequest;
            vis_q    <= (pixelX < SCREEN_W_L) && (pixelY < SCREEN_H_L);
        end
    end

    assign masked_req = req_q & {NUM_TILES{vis_q}};
    assign overlap    = (|masked_req) && player_q;

    tile_priority_encoder #(.N(NUM_TILES)) u_enc (
        .req_i   (masked_req),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    // Color of the winning tile; zero when nothing is requesting.
    always_comb begin
        sel_rgb = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            sel_rgb = (enc_valid && (enc_idx == tile_idx_t'(i)))
                      ? rgb_q[i*COLOR_W +: COLOR_W] : sel_rgb;
        end
    end

    // Stage 2: registered draw outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            tile_req_q <= 1'b0;
            tile_rgb_q <= '0;
            tile_idx_q <= 4'd0;
        end else begin
            tile_req_q <= enc_valid;
            tile_rgb_q <= sel_rgb;
            tile_idx_q <= enc_valid ? enc_idx : 4'd0;
        end
    end

    // Collision FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a frame start clears first, so a coincident overlap is the new frame's first hit.
    always_comb begin
        state_base = startOfFrame ? IDLE : state_q;
        case (state_base)
            IDLE:    state_d = overlap ? HIT : IDLE;
            HIT:     state_d = HIT;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: first-hit strobe and the index to latch.
    always_comb begin
        case (state_base)
            IDLE:    first_hit = overlap;
            HIT:     first_hit = 1'b0;
            default: first_hit = 1'b0;
        endcase
        if (first_hit) begin
            coll_idx_d = enc_idx;
        end else if (startOfFrame) begin
            coll_idx_d = 4'd0;
        end else begin
            coll_idx_d = coll_idx_q;
        end
    end

    // Registered collision outputs, aligned with stage 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            collision_q <= 1'b0;
            coll_idx_q  <= 4'd0;
        end else begin
            collision_q <= first_hit;
            coll_idx_q  <= coll_idx_d;
        end
    end

`ifdef STREET_TILE_HITCOUNT_EN
    logic [15:0] count_q, count_d;

    // Saturating overlap count, cleared at frame start before the current overlap is added.
    always_comb begin
        count_d = startOfFrame ? 16'd0 : count_q;
        if (overlap && (count_d != 16'hFFFF)) begin
            count_d = count_d + 16'd1;
        end else begin
            count_d = count_d;
        end
    end

    // Overlap counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign overlapPixelCount = count_q;
`else
    assign overlapPixelCount = 16'd0;
`endif

    assign tileDrawingRequest = tile_req_q;
    assign tileRGB            = tile_rgb_q;
    assign tileIndex          = tile_idx_q;
    assign tileCollision      = collision_q;
    assign collisionTileIndex = coll_idx_q;

endmodule
